// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: ALU control codes shared with the decoder, FSM states.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_DIVU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SRL  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  function automatic logic alu_is_muldiv(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_iter_muldiv: WIDTH-iteration shift-add multiplier / restoring   |
// | divider, used only when ALU_MULDIV_EN is defined.  Rev 1.0          |
// +--------------------------------------------------------------------+
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             op_i,      // 0: MUL, 1: DIVU
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_q, div_d;
  // acc: product / partial remainder; x: multiplicand / dividend->quotient; y: multiplier / divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   w_trial;

  always_comb begin
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div_d   = div_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    w_trial = {acc_q, x_q[WIDTH-1]} - {1'b0, y_q};
    if (start_i) begin
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
      div_d  = op_i;
      acc_d  = '0;
      x_d    = a_i;
      y_d    = b_i;
    end else if (busy_q) begin
      if (div_q) begin
        // A zero divisor never borrows, so the quotient saturates to all ones.
        if (!w_trial[WIDTH]) begin
          acc_d = w_trial[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[WIDTH-2:0], x_q[WIDTH-1]};
          x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (y_q[0]) begin
          acc_d = acc_q + x_q;
        end
        x_d = {x_q[WIDTH-2:0], 1'b0};
        y_d = {1'b0, y_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      div_q  <= div_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = div_q ? x_q : acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_exec_unit: execute-stage ALU with valid/ready handshake.        |
// | MUL/DIVU run iteratively only when ALU_MULDIV_EN is defined. Rev 1.0|
// +--------------------------------------------------------------------+
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic             w_accept;
  logic             w_is_md;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ill;

`ifdef ALU_MULDIV_EN
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_result;

  assign w_is_md    = alu_is_muldiv(alu_control);
  assign w_md_start = w_accept & w_is_md;

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_md_start),
    .op_i     (alu_control == ALU_DIVU),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (w_md_done),
    .result_o (w_md_result)
  );
`else
  assign w_is_md = 1'b0;
`endif

  assign w_shamt = src_b[SH_W-1:0];

  // MUL/DIVU land in the default arm; when the iterative path exists they are routed to BUSY instead.
  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (alu_control)
      ALU_ADD:  w_alu_res = src_a + src_b;
      ALU_SUB:  w_alu_res = src_a - src_b;
      ALU_AND:  w_alu_res = src_a & src_b;
      ALU_OR:   w_alu_res = src_a | src_b;
      ALU_XOR:  w_alu_res = src_a ^ src_b;
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      ALU_SLL:  w_alu_res = src_a << w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(src_a) >>> w_shamt);
      ALU_SRL:  w_alu_res = src_a >> w_shamt;
      default:  w_alu_ill = 1'b1;
    endcase
  end

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
        if (w_accept) begin
          if (w_is_md) begin
            state_d = S_BUSY;
          end else begin
            state_d   = S_DONE;
            result_d  = w_alu_res;
            illegal_d = w_alu_ill;
          end
        end
      end
`ifdef ALU_MULDIV_EN
      S_BUSY: begin
        if (w_md_done) begin
          state_d   = S_DONE;
          result_d  = w_md_result;
          illegal_d = 1'b0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_exec_unit: directed + randomized checks against a reference  |
// | model of the ALU op table.  Rev 1.0                                 |
// +--------------------------------------------------------------------+
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   alu_control = 4'd0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {illegal, result} straight from the operation table.
  function automatic logic [W:0] model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic [4:0] sh;
    sa = a;
    sh = b[4:0];
    case (code)
      4'd0:  return {1'b0, a + b};
      4'd1:  return {1'b0, a - b};
      4'd2:  return {1'b0, a & b};
      4'd3:  return {1'b0, a | b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'd6:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'd10: return {1'b0, a << sh};
      4'd11: return {1'b0, $unsigned(sa >>> sh)};
      4'd12: return {1'b0, a >> sh};
`ifdef ALU_MULDIV_EN
      4'd8:  return {1'b0, a * b};
      4'd9:  return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
`endif
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] code);
`ifdef ALU_MULDIV_EN
    if (code == 4'd8 || code == 4'd9) return W + 1;
`endif
    return 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from a negedge, then wait (bounded) for its result with out_ready=1.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] m;
    int n;
    bit got;
    m = model(code, a, b);
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_control = code;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_control = 4'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1'b1;
      else if (in_ready) check({tag, " busy in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    check({tag, " latency"}, n, model_lat(code));
    check({tag, " result"}, result, m[W-1:0]);
    check({tag, " illegal"}, {31'd0, illegal}, {31'd0, m[W]});
    check({tag, " zero"}, {31'd0, zero}, {31'd0, m[W-1:0] == 0});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd1);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    run_op("add wrap", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    run_op("sub zero", ALU_SUB, 32'd5, 32'd5);
    run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    run_op("sra", ALU_SRA, 32'h8000_0000, 32'h24);
    run_op("srl", ALU_SRL, 32'h8000_0000, 32'h24);
    run_op("sll", ALU_SLL, 32'd1, 32'd31);
    run_op("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op("ill 0111", 4'b0111, 32'd3, 32'd4);
    run_op("ill 1101", 4'b1101, 32'd3, 32'd4);
    run_op("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0003);
    run_op("divu", ALU_DIVU, 32'd100, 32'd7);
    run_op("divu by 0", ALU_DIVU, 32'd5, 32'd0);

    // Back-to-back ADDs: one result per cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b valid", {31'd0, out_valid}, 32'd1);
        check("b2b result", result, 32'(17 * (i - 1)));
      end
      if (i < 4) begin
        in_valid = 1'b1;
        alu_control = ALU_ADD;
        src_a = 32'(16 * i);
        src_b = 32'(i);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Consumer stall: result held, next request waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    alu_control = ALU_XOR;
    src_a = 32'hF0F0_0000;
    src_b = 32'h0F0F_FFFF;
    @(posedge clk);
    #1;
    alu_control = ALU_SUB;
    src_a = 32'd9;
    src_b = 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall valid", {31'd0, out_valid}, 32'd1);
      check("stall result", result, 32'hFFFF_FFFF);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("after stall valid", {31'd0, out_valid}, 32'd1);
    check("after stall result", result, 32'd5);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    in_valid = 1'b1;
`ifdef ALU_MULDIV_EN
    alu_control = ALU_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
`else
    out_ready = 1'b0;
    alu_control = ALU_ADD;
    src_a = 32'd100;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
`endif
    reset = 1'b1;
    #1;
    check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    check("mid rst result", result, 32'd0);
    check("mid rst zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) check("leftover output", {31'd0, out_valid}, 32'd0);
    end
    run_op("post rst add", ALU_ADD, 32'd2, 32'd3);

    for (int i = 0; i < 60; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU decoder, together with two operands, and returns a registered result. Single-cycle integer ops complete one cycle after acceptance. The two extended codes (1000 MUL, 1001 DIVU) run on an iterative shift-add/restoring datapath. A valid/ready handshake on both sides lets the unit stall the pipeline during multi-cycle ops.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 8.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request this cycle.
- alu_control  input  4  operation code from the ALU decoder.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; shift amount = src_b[$clog2(WIDTH)-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- illegal  output  1  accepted code was unsupported; qualified by out_valid.

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, 0/1), 0110 SLTU, 1010 SLL, 1011 SRA, 1100 SRL, 1000 MUL (low WIDTH bits of A*B), 1001 DIVU (unsigned quotient).
- Any other code (0111, 1101–1111, X): result 0, illegal=1, single-cycle path.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- DIVU with B=0: result all ones, illegal=0.
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0; iterative op running; counter counts WIDTH-1 down to 0.
  - DONE: out_valid=1; result held stable until out_ready.
- Transitions:
  - IDLE, accept of a single-cycle code → DONE.
  - IDLE, accept of 1000/1001 → BUSY.
  - BUSY with counter==0 → DONE.
  - DONE with out_ready: → IDLE, or re-enter DONE/BUSY if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready), giving back-to-back single-cycle throughput of 1 op/cycle.
- Operands and code are captured at acceptance; input changes during BUSY are ignored.
- zero is derived from the registered result.

## Timing
- Accept = in_valid & in_ready at a rising edge.
- Single-cycle ops: out_valid rises on the edge after acceptance (latency 1).
- MUL/DIVU: WIDTH iterations in BUSY, then DONE. out_valid rises WIDTH+1 cycles after acceptance (33 for WIDTH=32).
- out_valid held with stable result/zero/illegal while out_ready=0; no result is dropped.
- Reset (any state, including mid-BUSY): state IDLE, counter 0, partial product/remainder cleared.
  - Output values during reset: out_valid=0, result=0, zero=1, illegal=0, in_ready=1.
  - An in-flight op is discarded with no output.

## Configuration
- ALU_MULDIV_EN defined: MUL/DIVU execute as above on the iterative datapath.
- ALU_MULDIV_EN undefined:
  - Iterative datapath and BUSY state are absent.
  - Codes 1000/1001 are treated as illegal (result 0, illegal=1, latency 1).

## Structure
- alu_pkg holds:
  - localparams for all 4-bit ALU control codes (ALU_ADD … ALU_DIVU), shared with the ALU decoder;
  - the FSM state enum.
- Sub-module alu_iter_muldiv:
  - start/op/a/b inputs, done/result outputs;
  - contains the counter, shift-add multiplier and restoring divider;
  - instantiated only under ALU_MULDIV_EN.

## Test plan
- ADD 0x7FFFFFFF + 1 → 0x80000000 next cycle. SUB 5-5 → 0, zero=1. SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0.
- SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000. SRL same → 0x08000000. SLL 1 by 31 → 0x80000000.
- MUL 0x0001_0000 × 0x0001_0003 → 0x00030000, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
- DIVU 100/7 → 14. DIVU 5/0 → 0xFFFFFFFF, illegal=0. Without ALU_MULDIV_EN: code 1000 → result 0, illegal=1 after 1 cycle.
- Back-to-back ADDs with out_ready=1 → one result per cycle. Hold out_ready=0 for 3 cycles → result stable, in_ready=0, no loss.
- Assert reset 10 cycles into a DIVU → out_valid=0, in_ready=1 immediately. The next ADD 2+3 → 5 with latency 1.
